// File: rtl/lima2_pkg.sv
// rtl/lima2_pkg.sv - shared width, group-boundary constants and word type for the lima2 adder
package lima2_pkg;

    localparam int ADD_W    = 8;
    localparam int GRP0_MSB = 2;
    localparam int GRP1_MSB = 4;

    typedef logic [ADD_W-1:0] add_word_t;

endpackage

// File: rtl/lima2_full_adder.sv
// rtl/lima2_full_adder.sv - one-bit full adder cell used by the ripple groups
module lima2_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain majority carry and parity sum
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/lima2_hybrid_adder.sv
// rtl/lima2_hybrid_adder.sv - 8-bit ripple/lookahead/ripple adder with registered sum (optional ovf via LIMA2_OVERFLOW_EN)
module lima2_hybrid_adder
    import lima2_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [ADD_W-1:0] x,
    input  logic [ADD_W-1:0] y,
    input  logic             c0,
    output logic             out_valid,
    output logic [ADD_W-1:0] s,
    output logic             c8
`ifdef LIMA2_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    // c[i] is the carry into bit i; c[ADD_W] is the carry-out
    logic [ADD_W:0] c;
    add_word_t      sum;
    logic           g3, p3, g4, p4;

    assign c[0] = c0;

    // Ripple group 0: bits 0..GRP0_MSB
    for (genvar i = 0; i <= GRP0_MSB; i++) begin : g_grp0
        lima2_full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    // Lookahead group: c5 is formed straight from c3 so it does not wait on c4
    always_comb begin
        g3 = x[GRP0_MSB+1] & y[GRP0_MSB+1];
        p3 = x[GRP0_MSB+1] ^ y[GRP0_MSB+1];
        g4 = x[GRP1_MSB] & y[GRP1_MSB];
        p4 = x[GRP1_MSB] ^ y[GRP1_MSB];
        c[GRP0_MSB+2]     = g3 | (p3 & c[GRP0_MSB+1]);
        c[GRP1_MSB+1]     = g4 | (p4 & g3) | (p4 & p3 & c[GRP0_MSB+1]);
        sum[GRP0_MSB+1]   = p3 ^ c[GRP0_MSB+1];
        sum[GRP1_MSB]     = p4 ^ c[GRP0_MSB+2];
    end

    // Ripple group 2: bits GRP1_MSB+1..ADD_W-1
    for (genvar i = GRP1_MSB + 1; i < ADD_W; i++) begin : g_grp2
        lima2_full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    // Output register: load on valid, otherwise hold the last result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            c8        <= 1'b0;
`ifdef LIMA2_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s   <= sum;
                c8  <= c[ADD_W];
`ifdef LIMA2_OVERFLOW_EN
                ovf <= c[ADD_W-1] ^ c[ADD_W];
`endif
            end
        end
    end

endmodule

// File: tb/tb_lima2_hybrid_adder.sv
// tb/tb_lima2_hybrid_adder.sv - scoreboard bench for lima2_hybrid_adder (ovf checked when LIMA2_OVERFLOW_EN is defined)
module tb_lima2_hybrid_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] x = 8'h00;
    logic [7:0] y = 8'h00;
    logic       c0 = 1'b0;
    logic       out_valid;
    logic [7:0] s;
    logic       c8;
`ifdef LIMA2_OVERFLOW_EN
    logic       ovf;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       v;
        logic [7:0] s;
        logic       c8;
        logic       ovf;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_s   = 8'h00;
    logic       m_c8  = 1'b0;
    logic       m_ovf = 1'b0;

    lima2_hybrid_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .c0        (c0),
        .out_valid (out_valid),
        .s         (s),
        .c8        (c8)
`ifdef LIMA2_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic ovf_ref(input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [7:0] r;
        r = a + b + {7'd0, ci};
        return (a[7] == b[7]) && (r[7] != a[7]);
    endfunction

    task automatic cmp(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (q.size() == 0) return;
        e = q.pop_front();
        cmp({tag, ".out_valid"}, {8'd0, out_valid}, {8'd0, e.v});
        cmp({tag, ".s"}, {1'b0, s}, {1'b0, e.s});
        cmp({tag, ".c8"}, {8'd0, c8}, {8'd0, e.c8});
`ifdef LIMA2_OVERFLOW_EN
        cmp({tag, ".ovf"}, {8'd0, ovf}, {8'd0, e.ovf});
`endif
    endtask

    // At a falling edge: check the result of the previous step, then drive the next
    task automatic drive(input string tag, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic [7:0] es, input logic ec8);
        exp_t e;
        @(negedge clk);
        check_out(tag);
        in_valid = v;
        x        = a;
        y        = b;
        c0       = ci;
        if (v) begin
            m_s   = es;
            m_c8  = ec8;
            m_ovf = ovf_ref(a, b, ci);
        end
        e.v   = v;
        e.s   = m_s;
        e.c8  = m_c8;
        e.ovf = m_ovf;
        q.push_back(e);
    endtask

    task automatic drive_model(input string tag, input logic v, input logic [7:0] a,
                               input logic [7:0] b, input logic ci);
        logic [8:0] r;
        r = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        drive(tag, v, a, b, ci, r[7:0], r[8]);
    endtask

    initial begin
        // Reset state
        #2;
        cmp("rst.out_valid", {8'd0, out_valid}, 9'd0);
        cmp("rst.s", {1'b0, s}, 9'd0);
        cmp("rst.c8", {8'd0, c8}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed sums
        drive("d60_7f", 1'b1, 8'h60, 8'h7F, 1'b0, 8'hDF, 1'b0);
        drive("dff_fe", 1'b1, 8'hFF, 8'hFE, 1'b0, 8'hFD, 1'b1);
        drive("daa_55", 1'b1, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
        drive("d08_81", 1'b1, 8'h08, 8'h81, 1'b0, 8'h89, 1'b0);
        drive("d08_81c", 1'b1, 8'h08, 8'h81, 1'b1, 8'h8A, 1'b0);
        drive("d01_00c", 1'b1, 8'h01, 8'h00, 1'b1, 8'h02, 1'b0);
        drive("df0_88c", 1'b1, 8'hF0, 8'h88, 1'b1, 8'h79, 1'b1);
        drive("cla_bnd", 1'b1, 8'h07, 8'h18, 1'b1, 8'h20, 1'b0);
        drive("full_prop", 1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        drive("c0_only", 1'b1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // Handshake 1,0,1 with hold while idle (idle operands differ on purpose)
        drive("hs1", 1'b1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        drive("hs0", 1'b0, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0);
        drive("hs1b", 1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        drive("hs0b", 1'b0, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
        drive("hs0c", 1'b0, 8'h02, 8'h02, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset mid-cycle with a valid result loaded
        drive("pre_rst", 1'b1, 8'h5A, 8'h5A, 1'b1, 8'hB5, 1'b0);
        @(posedge clk);
        #2;
        check_out("pre_rst");
        rst_n = 1'b0;
        #1;
        cmp("arst.out_valid", {8'd0, out_valid}, 9'd0);
        cmp("arst.s", {1'b0, s}, 9'd0);
        cmp("arst.c8", {8'd0, c8}, 9'd0);
`ifdef LIMA2_OVERFLOW_EN
        cmp("arst.ovf", {8'd0, ovf}, 9'd0);
`endif
        q.delete();
        m_s = 8'h00; m_c8 = 1'b0; m_ovf = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive("post_rst", 1'b0, 8'h33, 8'h44, 1'b0, 8'h00, 1'b0);

        // Random sweep, mostly valid with occasional idle cycles
        for (int i = 0; i < 10000; i++) begin
            drive_model("rnd", ($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom),
                        1'($urandom));
        end

        drive("flush", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_out("flush");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
